mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Block-transfer initiator that drives the single-port data memory's address/read/write interface to copy or fill a contiguous byte range without processor involvement. It sits beside the core on the data-memory port. The core programs source, destination, length and mode, then pulses `start`. The engine reports `busy` and a one-cycle `done`. Port arbitration is external: the core must not access data memory while `busy` is high.

## Interface
Parameters:
- `AW`, 8, address width; data memory depth is 2^AW.
- `DW`, 8, data width.

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `Mode`  in  1  0 = copy, 1 = fill; latched at accepted `start`.
- `SrcAddr`  in  AW  copy source base; latched at accepted `start`.
- `DstAddr`  in  AW  destination base; latched at accepted `start`.
- `Length`  in  AW  byte count, 0..255; latched at accepted `start`.
- `FillValue`  in  DW  fill byte; latched at accepted `start`.
- `MemRdData`  in  DW  combinational read data returned by the memory.
- `MemAddr`  out  AW  address presented to the memory.
- `MemRead`  out  1  read enable; memory returns data in the same cycle.
- `MemWrite`  out  1  write enable; memory writes on the next rising edge.
- `MemWrData`  out  DW  write data.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Registers:
  - latched src, dst, len, mode, fill;
  - byte index `idx` (AW bits);
  - holding register `hold` (DW bits).
- States:
  - IDLE: waits for `start`.
  - RD: copy only; `MemRead`=1, `MemAddr`=src+idx, `hold` <= `MemRdData` at the edge.
  - WR: `MemWrite`=1, `MemAddr`=dst+idx, `MemWrData`=`hold` (copy) or fill (fill).
  - DONE: single cycle.
- Transitions:
  - IDLE, `start`=1, `Length`=0 -> DONE.
  - IDLE, `start`=1, copy -> RD.
  - IDLE, `start`=1, fill -> WR.
  - RD -> WR.
  - WR: if idx == len-1 -> DONE; else idx <= idx+1, then -> RD (copy) or WR (fill).
  - DONE -> IDLE.
- Address arithmetic is mod 2^AW. src+idx and dst+idx wrap from 255 to 0 silently.
- `idx` is cleared at accepted `start`.
- Copy order is strictly ascending. With overlapping ranges where dst is in (src, src+len), already-written bytes are re-read. This propagation is the defined behaviour; no memmove semantics.
- Outside RD/WR: `MemRead`=0, `MemWrite`=0, `MemAddr`=0. `MemRead` and `MemWrite` are never high together.
- `MemWrData` = `hold` whenever not in a fill WR.
- `busy` = state is RD or WR. `done` = state is DONE.
- `start` outside IDLE, including during DONE, is ignored. Input changes after acceptance have no effect.
- Reset, including mid-transfer:
  - takes effect immediately, without waiting for a clock edge;
  - state -> IDLE; idx, hold and all latched registers -> 0;
  - every output -> 0 (`MemRead`, `MemWrite`, `MemAddr`, `MemWrData`, `busy`, `done`);
  - a partially copied range is left as-is.

## Timing
- `start` is accepted at edge E0.
- Copy of N≥1 bytes:
  - byte i uses RD in cycle 2i+1 and WR in cycle 2i+2 (cycles counted after E0);
  - DONE occupies cycle 2N+1;
  - IDLE from cycle 2N+2; earliest next accepted `start` is at the edge ending cycle 2N+1... no: at the first edge in IDLE, i.e. the edge ending cycle 2N+2.
- Fill of N≥1 bytes: WR in cycles 1..N, DONE in cycle N+1.
- Length 0: DONE in cycle 1, with no memory access.
- `busy` is high exactly during the RD/WR cycles. `done` is high exactly one cycle.
- Read data is captured at the RD→WR edge. The memory write commits at the edge ending the WR cycle.
- Throughput is 2 cycles/byte for copy and 1 cycle/byte for fill.

## Test plan
- **Copy, 4 bytes.**
  - Stimulus: M[16..19]=1,2,3,4; copy src=16, dst=100, len=4.
  - Response: M[100..103]=1,2,3,4; `busy` high 8 cycles; `done` in cycle 9; exactly 4 reads and 4 writes.
- **Fill with wrap.**
  - Stimulus: fill dst=254, len=4, value=0xA5.
  - Response: M[254], M[255], M[0], M[1] = 0xA5; M[2] unchanged; `done` in cycle 5.
- **Length 0.**
  - Stimulus: copy with len=0.
  - Response: `done` in cycle 1; `busy` never high; `MemRead`/`MemWrite` never high.
- **Overlapping forward copy.**
  - Stimulus: M[10..12]=7,8,9; copy src=10, dst=11, len=2.
  - Response: M[11]=7, M[12]=7 (propagation).
- **Start ignored and inputs latched.**
  - Stimulus: during a len=3 copy, pulse `start` with different addresses, and change `SrcAddr` mid-transfer.
  - Response: original transfer completes unchanged; a single `done`.
- **Async reset mid-transfer.**
  - Stimulus: assert `reset` between edges during the WR of byte 1 in a len=4 copy.
  - Response: all outputs 0 immediately; only byte 0 written; a new `start` after release runs normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Block-transfer initiator on the data-memory port. Copies or
//                fills a contiguous byte range using ascending addresses that
//                wrap modulo 2^AW. Every memory-side output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  input  logic [DW-1:0] FillValue,
  input  logic [DW-1:0] MemRdData,
  output logic [AW-1:0] MemAddr,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [DW-1:0] MemWrData,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] c_one = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW-1:0] r_len;
  logic          r_mode;
  logic [DW-1:0] r_fill;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_hold;

  logic [AW-1:0] w_next_idx;
  logic          w_last;

  // Next byte index and the final-byte test for the WR state.
  assign w_next_idx = r_idx + c_one;
  assign w_last     = (r_idx == (r_len - c_one));

  // Transfer FSM; outputs are precomputed for the state being entered so that
  // they are registered yet line up exactly with the state they belong to.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_mode    <= 1'b0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_hold    <= '0;
      MemAddr   <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemWrData <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          MemAddr   <= '0;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b0;
          MemWrData <= r_hold;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            r_src  <= SrcAddr;
            r_dst  <= DstAddr;
            r_len  <= Length;
            r_mode <= Mode;
            r_fill <= FillValue;
            r_idx  <= '0;
            if (Length == '0) begin
              // Empty transfer: straight to completion, no memory access.
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else if (!Mode) begin
              r_state <= ST_RD;
              MemRead <= 1'b1;
              MemAddr <= SrcAddr;
              busy    <= 1'b1;
            end else begin
              r_state   <= ST_WR;
              MemWrite  <= 1'b1;
              MemAddr   <= DstAddr;
              MemWrData <= FillValue;
              busy      <= 1'b1;
            end
          end
        end

        ST_RD: begin
          // Capture the source byte and present it straight away for the write.
          r_hold    <= MemRdData;
          r_state   <= ST_WR;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b1;
          MemAddr   <= r_dst + r_idx;
          MemWrData <= MemRdData;
          busy      <= 1'b1;
        end

        ST_WR: begin
          if (w_last) begin
            r_state   <= ST_DONE;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            MemAddr   <= '0;
            MemWrData <= r_hold;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_idx <= w_next_idx;
            busy  <= 1'b1;
            if (!r_mode) begin
              r_state   <= ST_RD;
              MemRead   <= 1'b1;
              MemWrite  <= 1'b0;
              MemAddr   <= r_src + w_next_idx;
              MemWrData <= r_hold;
            end else begin
              r_state   <= ST_WR;
              MemRead   <= 1'b0;
              MemWrite  <= 1'b1;
              MemAddr   <= r_dst + w_next_idx;
              MemWrData <= r_fill;
            end
          end
        end

        default: begin
          // DONE: a start seen here is deliberately dropped.
          r_state   <= ST_IDLE;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b0;
          MemAddr   <= '0;
          MemWrData <= r_hold;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_engine
//  Description : Directed self-checking bench for mem_copy_engine with a
//                256-byte combinational-read memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic       Mode;
  logic [7:0] SrcAddr, DstAddr, Length, FillValue;
  logic [7:0] MemRdData, MemAddr, MemWrData;
  logic       MemRead, MemWrite, busy, done;

  logic [7:0] mem [0:255];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .reset(reset), .start(start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
    .FillValue(FillValue), .MemRdData(MemRdData), .MemAddr(MemAddr),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemWrData(MemWrData),
    .busy(busy), .done(done)
  );

  // Memory model: combinational read, write on rising edge; bench preload
  // port is used only while the engine is idle.
  assign MemRdData = mem[MemAddr];
  always @(posedge CLK) begin
    if (MemWrite) mem[MemAddr] <= MemWrData;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge CLK);
    tb_we = 1'b0;
  endtask

  // Issue one transfer and observe it cycle by cycle (cycle k = k-th cycle
  // after the accepting edge). Optional disturbance: re-pulse start with other
  // operands and change SrcAddr mid-transfer, and pulse start during DONE.
  task automatic run(input logic md, input logic [7:0] src, input logic [7:0] dst,
                     input logic [7:0] len, input logic [7:0] fv, input bit disturb,
                     output int busy_cyc, output int done_cyc, output int ndone,
                     output int nrd, output int nwr, output int nboth);
    busy_cyc = 0; done_cyc = 0; ndone = 0; nrd = 0; nwr = 0; nboth = 0;
    @(negedge CLK);
    Mode = md; SrcAddr = src; DstAddr = dst; Length = len; FillValue = fv; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (disturb && k == 3) begin
        start = 1'b1; SrcAddr = 8'd200; DstAddr = 8'd201; Length = 8'd1; Mode = 1'b1;
      end
      if (busy) busy_cyc++;
      if (done) begin
        ndone++;
        if (done_cyc == 0) begin
          done_cyc = k;
          if (disturb) start = 1'b1;
        end
      end
      if (MemRead) nrd++;
      if (MemWrite) nwr++;
      if (MemRead && MemWrite) nboth++;
      if (done_cyc != 0 && k >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  int bc, dc, nd, nr, nw, nb;

  initial begin
    reset = 1'b1; start = 1'b0; Mode = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
    #2;
    check("rst_outputs", {MemRead, MemWrite, busy, done, MemAddr, MemWrData}, 32'h0);
    for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
    @(negedge CLK);
    reset = 1'b0;

    // Copy of 4 bytes
    poke(8'd16, 8'd1); poke(8'd17, 8'd2); poke(8'd18, 8'd3); poke(8'd19, 8'd4);
    run(1'b0, 8'd16, 8'd100, 8'd4, 8'h00, 1'b0, bc, dc, nd, nr, nw, nb);
    check("copy4_busy", bc, 8);
    check("copy4_done", dc, 9);
    check("copy4_ndone", nd, 1);
    check("copy4_rd", nr, 4);
    check("copy4_wr", nw, 4);
    check("copy4_both", nb, 0);
    check("copy4_data", {mem[100], mem[101], mem[102], mem[103]}, 32'h01020304);

    // Fill wrapping past the top of memory
    poke(8'd2, 8'h33);
    run(1'b1, 8'd0, 8'd254, 8'd4, 8'hA5, 1'b0, bc, dc, nd, nr, nw, nb);
    check("fill_done", dc, 5);
    check("fill_busy", bc, 4);
    check("fill_rd", nr, 0);
    check("fill_wr", nw, 4);
    check("fill_data", {mem[254], mem[255], mem[0], mem[1]}, 32'hA5A5A5A5);
    check("fill_m2", mem[2], 8'h33);

    // Zero length
    run(1'b0, 8'd16, 8'd120, 8'd0, 8'h00, 1'b0, bc, dc, nd, nr, nw, nb);
    check("len0_done", dc, 1);
    check("len0_busy", bc, 0);
    check("len0_rdwr", nr + nw, 0);

    // Overlapping forward copy propagates
    poke(8'd10, 8'd7); poke(8'd11, 8'd8); poke(8'd12, 8'd9);
    run(1'b0, 8'd10, 8'd11, 8'd2, 8'h00, 1'b0, bc, dc, nd, nr, nw, nb);
    check("ovl_data", {mem[10], mem[11], mem[12]}, 32'h070707);
    check("ovl_done", dc, 5);

    // Restart and input changes ignored mid-transfer and during DONE
    poke(8'd30, 8'h11); poke(8'd31, 8'h22); poke(8'd32, 8'h33);
    poke(8'd201, 8'h5A);
    run(1'b0, 8'd30, 8'd60, 8'd3, 8'h00, 1'b1, bc, dc, nd, nr, nw, nb);
    check("ign_done", dc, 7);
    check("ign_ndone", nd, 1);
    check("ign_busy", bc, 6);
    check("ign_wr", nw, 3);
    check("ign_data", {mem[60], mem[61], mem[62]}, 32'h112233);
    check("ign_m201", mem[201], 8'h5A);
    @(negedge CLK);
    check("ign_idle", {busy, done}, 32'h0);

    // Asynchronous reset during the WR of byte 1
    poke(8'd150, 8'h55); poke(8'd151, 8'h55);
    @(negedge CLK);
    Mode = 1'b0; SrcAddr = 8'd16; DstAddr = 8'd150; Length = 8'd4; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst_pre_wr", {MemWrite, MemAddr}, {23'h0, 1'b1, 8'd151});
    #1 reset = 1'b1;
    #1;
    check("rst_async_out", {MemRead, MemWrite, busy, done, MemAddr, MemWrData}, 32'h0);
    @(negedge CLK);
    reset = 1'b0;
    check("rst_mem", {mem[150], mem[151]}, 32'h0155);
    run(1'b0, 8'd18, 8'd160, 8'd1, 8'h00, 1'b0, bc, dc, nd, nr, nw, nb);
    check("rst_after_done", dc, 3);
    check("rst_after_data", mem[160], 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
